// File: rtl/riscv_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU operation codes
// and forwarding-select codes.
package riscv_pkg;

  localparam int XLEN = 32;

  // Codes 100, 110 and 111 are unassigned and fall through to add in the ALU.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  // 11 is unassigned and selects the register-file value, like 00.
  typedef enum logic [1:0] {
    FWD_RD = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/execute_stage_if.sv
// Port bundle of the execute stage: decode-side inputs, hazard controls,
// forwarding inputs and the MEM-side / hazard-unit outputs.
interface execute_stage_if #(parameter int XLEN = 32);

  logic            StallE;
  logic            FlushE;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;

  logic            RegWriteD;
  logic [1:0]      ResultSrcD;
  logic            MemWriteD;
  logic            JumpD;
  logic            BranchD;
  logic [2:0]      ALUControlD;
  logic            ALUSrcD;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] ImmExtD;
  logic [XLEN-1:0] PCPlus4D;
  logic [4:0]      RdD;

  logic            RegWriteM;
  logic [1:0]      ResultSrcM;
  logic            MemWriteM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [4:0]      RdM;
  logic [XLEN-1:0] PCPlus4M;
  logic [4:0]      RdE;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;

  modport master (
    output StallE, FlushE, ForwardAE, ForwardBE, ResultW,
           RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD,
           ALUSrcD, RD1D, RD2D, PCD, ImmExtD, PCPlus4D, RdD,
    input  RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM,
           PCPlus4M, RdE, PCSrcE, PCTargetE
  );

  modport slave (
    input  StallE, FlushE, ForwardAE, ForwardBE, ResultW,
           RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD,
           ALUSrcD, RD1D, RD2D, PCD, ImmExtD, PCPlus4D, RdD,
    output RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM,
           PCPlus4M, RdE, PCSrcE, PCTargetE
  );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational ALU: add, sub, and, or and signed set-less-than.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  alu_op_e         i_op,
  output logic [XLEN-1:0] o_result
);

  always_comb begin
    o_result = i_a + i_b;
    case (i_op)
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_SLT: o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: ;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of a five-stage RISC-V pipeline: ID/EX register, operand
// forwarding, ALU, branch resolution and the EX/MEM register.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input logic             clk,
  input logic             rst_n,
  execute_stage_if.slave  bus
);

  logic            r_reg_write_e;
  logic [1:0]      r_result_src_e;
  logic            r_mem_write_e;
  logic            r_jump_e;
  logic            r_branch_e;
  logic [2:0]      r_alu_ctrl_e;
  logic            r_alu_src_e;
  logic [XLEN-1:0] r_rd1_e;
  logic [XLEN-1:0] r_rd2_e;
  logic [XLEN-1:0] r_pc_e;
  logic [XLEN-1:0] r_imm_e;
  logic [XLEN-1:0] r_pc_plus4_e;
  logic [4:0]      r_rd_e;

  logic            r_reg_write_m;
  logic [1:0]      r_result_src_m;
  logic            r_mem_write_m;
  logic [XLEN-1:0] r_alu_result_m;
  logic [XLEN-1:0] r_write_data_m;
  logic [4:0]      r_rd_m;
  logic [XLEN-1:0] r_pc_plus4_m;

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_write_data;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_zero;

  // Flush beats stall: a flushed instruction must not linger in a held register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.FlushE) begin
      r_reg_write_e  <= 1'b0;
      r_result_src_e <= 2'b00;
      r_mem_write_e  <= 1'b0;
      r_jump_e       <= 1'b0;
      r_branch_e     <= 1'b0;
      r_alu_ctrl_e   <= 3'b000;
      r_alu_src_e    <= 1'b0;
      r_rd1_e        <= '0;
      r_rd2_e        <= '0;
      r_pc_e         <= '0;
      r_imm_e        <= '0;
      r_pc_plus4_e   <= '0;
      r_rd_e         <= 5'd0;
    end else if (!bus.StallE) begin
      r_reg_write_e  <= bus.RegWriteD;
      r_result_src_e <= bus.ResultSrcD;
      r_mem_write_e  <= bus.MemWriteD;
      r_jump_e       <= bus.JumpD;
      r_branch_e     <= bus.BranchD;
      r_alu_ctrl_e   <= bus.ALUControlD;
      r_alu_src_e    <= bus.ALUSrcD;
      r_rd1_e        <= bus.RD1D;
      r_rd2_e        <= bus.RD2D;
      r_pc_e         <= bus.PCD;
      r_imm_e        <= bus.ImmExtD;
      r_pc_plus4_e   <= bus.PCPlus4D;
      r_rd_e         <= bus.RdD;
    end
  end

  // M-stage forwarding taps the registered result, so no extra stall is needed.
  always_comb begin
    w_src_a = r_rd1_e;
    case (fwd_sel_e'(bus.ForwardAE))
      FWD_W:   w_src_a = bus.ResultW;
      FWD_M:   w_src_a = r_alu_result_m;
      default: ;
    endcase
  end

  always_comb begin
    w_write_data = r_rd2_e;
    case (fwd_sel_e'(bus.ForwardBE))
      FWD_W:   w_write_data = bus.ResultW;
      FWD_M:   w_write_data = r_alu_result_m;
      default: ;
    endcase
  end

  assign w_src_b = r_alu_src_e ? r_imm_e : w_write_data;

  alu #(.XLEN(XLEN)) u_alu (
    .i_a      (w_src_a),
    .i_b      (w_src_b),
    .i_op     (alu_op_e'(r_alu_ctrl_e)),
    .o_result (w_alu_result)
  );

  assign w_zero = (w_alu_result == '0);

  // A stalled E stage still holds its instruction, so MEM must receive a bubble
  // rather than a duplicate of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || (bus.StallE && !bus.FlushE)) begin
      r_reg_write_m  <= 1'b0;
      r_result_src_m <= 2'b00;
      r_mem_write_m  <= 1'b0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_rd_m         <= 5'd0;
      r_pc_plus4_m   <= '0;
    end else begin
      r_reg_write_m  <= r_reg_write_e;
      r_result_src_m <= r_result_src_e;
      r_mem_write_m  <= r_mem_write_e;
      r_alu_result_m <= w_alu_result;
      r_write_data_m <= w_write_data;
      r_rd_m         <= r_rd_e;
      r_pc_plus4_m   <= r_pc_plus4_e;
    end
  end

  assign bus.RegWriteM  = r_reg_write_m;
  assign bus.ResultSrcM = r_result_src_m;
  assign bus.MemWriteM  = r_mem_write_m;
  assign bus.ALUResultM = r_alu_result_m;
  assign bus.WriteDataM = r_write_data_m;
  assign bus.RdM        = r_rd_m;
  assign bus.PCPlus4M   = r_pc_plus4_m;
  assign bus.RdE        = r_rd_e;
  assign bus.PCSrcE     = r_jump_e | (r_branch_e & w_zero);
  assign bus.PCTargetE  = r_pc_e + r_imm_e;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, ALU ops, branch resolution,
// forwarding, stall/flush behaviour and asynchronous reset mid-stream.
module tb_execute_stage;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  execute_stage_if #(.XLEN(32)) bus ();

  execute_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src, input logic rw,
                       input logic mw, input logic br, input logic jp,
                       input logic [31:0] pc, input logic [4:0] rd);
    bus.ALUControlD = op;
    bus.RD1D        = a;
    bus.RD2D        = b;
    bus.ImmExtD     = imm;
    bus.ALUSrcD     = src;
    bus.RegWriteD   = rw;
    bus.MemWriteD   = mw;
    bus.BranchD     = br;
    bus.JumpD       = jp;
    bus.PCD         = pc;
    bus.PCPlus4D    = pc + 32'd4;
    bus.RdD         = rd;
    bus.ResultSrcD  = {1'b0, rw};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_regwm"},  {31'd0, bus.RegWriteM}, 32'd0);
    chk({tag, "_ressm"},  {30'd0, bus.ResultSrcM}, 32'd0);
    chk({tag, "_memwm"},  {31'd0, bus.MemWriteM}, 32'd0);
    chk({tag, "_alum"},   bus.ALUResultM, 32'd0);
    chk({tag, "_wdm"},    bus.WriteDataM, 32'd0);
    chk({tag, "_rdm"},    {27'd0, bus.RdM}, 32'd0);
    chk({tag, "_pc4m"},   bus.PCPlus4M, 32'd0);
    chk({tag, "_rde"},    {27'd0, bus.RdE}, 32'd0);
    chk({tag, "_pcsrc"},  {31'd0, bus.PCSrcE}, 32'd0);
    chk({tag, "_pctgt"},  bus.PCTargetE, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.StallE    = 1'b0;
    bus.FlushE    = 1'b0;
    bus.ForwardAE = 2'b00;
    bus.ForwardBE = 2'b00;
    bus.ResultW   = 32'd0;
    drive(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0);

    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // sub 5 - 7
    drive(3'b001, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 5'd3);
    tick();
    chk("sub_rde", {27'd0, bus.RdE}, 32'd3);
    tick();
    chk("sub_res", bus.ALUResultM, 32'hFFFF_FFFE);
    chk("sub_regwm", {31'd0, bus.RegWriteM}, 32'd1);
    chk("sub_rdm", {27'd0, bus.RdM}, 32'd3);
    chk("sub_pc4m", bus.PCPlus4M, 32'h44);
    chk("sub_ressm", {30'd0, bus.ResultSrcM}, 32'd1);
    chk("sub_wdm", bus.WriteDataM, 32'd7);

    // slt -1 < 1 and 1 < -1
    drive(3'b101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd4);
    tick(); tick();
    chk("slt_neg_pos", bus.ALUResultM, 32'd1);
    drive(3'b101, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd4);
    tick(); tick();
    chk("slt_pos_neg", bus.ALUResultM, 32'd0);

    // and, or with immediate, unassigned code 110 acting as add
    drive(3'b010, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd1);
    tick(); tick();
    chk("and_res", bus.ALUResultM, 32'h0000_F000);
    drive(3'b011, 32'h10, 32'h77, 32'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd1);
    tick(); tick();
    chk("ori_res", bus.ALUResultM, 32'h15);
    chk("ori_wdm", bus.WriteDataM, 32'h77);
    drive(3'b110, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd1);
    tick(); tick();
    chk("op110_res", bus.ALUResultM, 32'd7);

    // beq taken then not taken
    drive(3'b001, 32'd3, 32'd3, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 5'd0);
    tick();
    chk("beq_taken", {31'd0, bus.PCSrcE}, 32'd1);
    chk("beq_target", bus.PCTargetE, 32'h120);
    drive(3'b001, 32'd3, 32'd4, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 5'd0);
    tick();
    chk("beq_not_taken", {31'd0, bus.PCSrcE}, 32'd0);
    chk("beq_target2", bus.PCTargetE, 32'h120);

    // forward A from M: 8+8 then (fwd 0x10)+1
    drive(3'b000, 32'd8, 32'd8, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd5);
    tick();
    drive(3'b000, 32'hDEAD, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd6);
    tick();
    chk("fwd_a_first", bus.ALUResultM, 32'h10);
    bus.ForwardAE = 2'b10;
    tick();
    chk("fwd_a_dep", bus.ALUResultM, 32'h11);
    bus.ForwardAE = 2'b00;

    // forward B from W into store data and ALU operand
    drive(3'b000, 32'd2, 32'h99, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0);
    tick();
    bus.ForwardBE = 2'b01;
    bus.ResultW   = 32'h40;
    tick();
    chk("fwd_b_wdm", bus.WriteDataM, 32'h40);
    chk("fwd_b_res", bus.ALUResultM, 32'h42);
    chk("fwd_b_memwm", {31'd0, bus.MemWriteM}, 32'd1);
    bus.ForwardBE = 2'b00;

    // stall for two cycles then release
    drive(3'b000, 32'h100, 32'h23, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 5'd7);
    tick();
    chk("stall_pre_rde", {27'd0, bus.RdE}, 32'd7);
    bus.StallE = 1'b1;
    drive(3'b000, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 5'd9);
    tick();
    chk("stall1_regwm", {31'd0, bus.RegWriteM}, 32'd0);
    chk("stall1_memwm", {31'd0, bus.MemWriteM}, 32'd0);
    chk("stall1_rdm", {27'd0, bus.RdM}, 32'd0);
    chk("stall1_rde", {27'd0, bus.RdE}, 32'd7);
    tick();
    chk("stall2_regwm", {31'd0, bus.RegWriteM}, 32'd0);
    chk("stall2_rde", {27'd0, bus.RdE}, 32'd7);
    bus.StallE = 1'b0;
    tick();
    chk("unstall_res", bus.ALUResultM, 32'h123);
    chk("unstall_rdm", {27'd0, bus.RdM}, 32'd7);
    chk("unstall_regwm", {31'd0, bus.RegWriteM}, 32'd1);
    chk("unstall_wdm", bus.WriteDataM, 32'h23);
    chk("unstall_rde", {27'd0, bus.RdE}, 32'd9);
    chk("unstall_pctgt", bus.PCTargetE, 32'h300);

    // stall and flush together: E takes a bubble, M takes the EX instruction
    bus.StallE = 1'b1;
    bus.FlushE = 1'b1;
    tick();
    chk("flush_rde", {27'd0, bus.RdE}, 32'd0);
    chk("flush_pctgt", bus.PCTargetE, 32'd0);
    chk("flush_rdm", {27'd0, bus.RdM}, 32'd9);
    chk("flush_res", bus.ALUResultM, 32'd3);
    bus.StallE = 1'b0;
    bus.FlushE = 1'b0;

    // asynchronous reset mid-stream with a jump in E and a write in M
    drive(3'b000, 32'd4, 32'd4, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 5'd10);
    tick(); tick();
    chk("pre_rst_regwm", {31'd0, bus.RegWriteM}, 32'd1);
    chk("pre_rst_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    chk("rst_held_rde", {27'd0, bus.RdE}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rde", {27'd0, bus.RdE}, 32'd10);
    chk("post_rst_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
    chk("post_rst_pctgt", bus.PCTargetE, 32'h208);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
